// File: rtl/memsys_lru_pkg.sv
// Shared helpers for the tree pseudo-LRU replacement state: tree sizing,
// heap-order node indexing along a way's path, and the controller FSM states.
package memsys_lru_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } lru_state_e;

    function automatic int tree_nodes(input int ways_log2);
        return (1 << ways_log2) - 1;
    endfunction

    // Heap order: level l starts at node 2**l-1, offset by the top l bits of the way.
    function automatic int path_node(input int way, input int level, input int ways_log2);
        return ((1 << level) - 1) + (way >> (ways_log2 - level));
    endfunction

endpackage

// File: rtl/plru_set_array_if.sv
// Lookup / touch / victim bundle between the cache controller (master)
// and the per-set PLRU state array (slave).
interface plru_set_array_if #(
    parameter int ways_log2_p = 2,
    parameter int sets_log2_p = 4
) ();
    logic                          ready_o;
    logic                          lookup_v_i;
    logic [sets_log2_p-1:0]        lookup_set_i;
    logic [(1 << ways_log2_p)-1:0] way_valid_i;
    logic [(1 << ways_log2_p)-1:0] lock_i;
    logic                          victim_v_o;
    logic [ways_log2_p-1:0]        victim_way_o;
    logic                          victim_none_o;
    logic                          touch_v_i;
    logic [sets_log2_p-1:0]        touch_set_i;
    logic [ways_log2_p-1:0]        touch_way_i;

    modport master (
        input  ready_o, victim_v_o, victim_way_o, victim_none_o,
        output lookup_v_i, lookup_set_i, way_valid_i, lock_i,
               touch_v_i, touch_set_i, touch_way_i
    );

    modport slave (
        output ready_o, victim_v_o, victim_way_o, victim_none_o,
        input  lookup_v_i, lookup_set_i, way_valid_i, lock_i,
               touch_v_i, touch_set_i, touch_way_i
    );
endinterface

// File: rtl/plru_tree_pick.sv
// Combinational PLRU tree walk: follows the flags from the root, steering
// away from any subtree whose ways are all locked.
module plru_tree_pick
    import memsys_lru_pkg::*;
#(
    parameter int ways_log2_p = 2
) (
    input  logic [(1 << ways_log2_p)-2:0] flags_i,
    input  logic [(1 << ways_log2_p)-1:0] lock_i,
    output logic [ways_log2_p-1:0]        way_o,
    output logic                          none_o
);
    localparam int LEAVES = 1 << ways_log2_p;

    int                       pos;
    int                       half;
    logic                     lft_all;
    logic                     rgt_all;
    logic                     dir;
    logic [LEAVES-1:0]        lock_sh;
    logic [LEAVES-2:0]        flag_sh;

    always_comb begin
        pos     = 0;
        half    = 1;
        lft_all = 1'b1;
        rgt_all = 1'b1;
        dir     = 1'b0;
        lock_sh = '0;
        flag_sh = '0;
        none_o  = &lock_i;
        for (int lvl = 0; lvl < ways_log2_p; lvl++) begin
            half    = 1 << (ways_log2_p - lvl - 1);
            lft_all = 1'b1;
            rgt_all = 1'b1;
            // pos is the way prefix chosen so far; its two children span 2*half leaves
            for (int k = 0; k < LEAVES; k++) begin
                lock_sh = lock_i >> k;
                if (k >= 2 * pos * half && k < (2 * pos + 1) * half && !lock_sh[0])
                    lft_all = 1'b0;
                if (k >= (2 * pos + 1) * half && k < (2 * pos + 2) * half && !lock_sh[0])
                    rgt_all = 1'b0;
            end
            flag_sh = flags_i >> path_node(pos << (ways_log2_p - lvl), lvl, ways_log2_p);
            dir     = flag_sh[0];
            if (dir && rgt_all) begin
                dir = 1'b0;
            end else if (!dir && lft_all) begin
                dir = 1'b1;
            end
            pos = pos * 2 + int'(dir);
        end
        way_o = none_o ? '0 : pos[ways_log2_p-1:0];
    end

endmodule

// File: rtl/plru_set_array.sv
// Per-set tree pseudo-LRU state with an init sweep, one-cycle touch commit,
// same-set touch bypass and invalid-first / lock-aware victim selection.
module plru_set_array
    import memsys_lru_pkg::*;
#(
    parameter int ways_log2_p = 2,
    parameter int sets_log2_p = 4
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    plru_set_array_if.slave  bus
);
    localparam int WAYS  = 1 << ways_log2_p;
    localparam int SETS  = 1 << sets_log2_p;
    localparam int NODES = tree_nodes(ways_log2_p);

    typedef logic [NODES-1:0]       tree_t;
    typedef logic [ways_log2_p-1:0] way_t;
    typedef logic [sets_log2_p-1:0] set_t;

    lru_state_e state_q, state_d;
    set_t       sweep_q, sweep_d;
    tree_t      flags_q [SETS];
    tree_t      flags_d [SETS];
    logic       victim_v_q, victim_v_d;
    way_t       victim_way_q, victim_way_d;
    logic       victim_none_q, victim_none_d;

    logic       ready;
    logic       lookup_go;
    logic       touch_go;
    tree_t      touched_flags;
    tree_t      lookup_flags;
    tree_t      node_mask;
    way_t       way_sh;
    logic [WAYS-1:0] free_mask;
    logic [WAYS-1:0] free_sh;
    logic       free_hit;
    way_t       free_way;
    way_t       pick_way;
    logic       pick_none;

    assign ready     = (state_q == ST_READY);
    assign lookup_go = ready & bus.lookup_v_i;
    assign touch_go  = ready & bus.touch_v_i;

    // Touched tree: every node on the way's path points away from that way
    always_comb begin
        touched_flags = flags_q[bus.touch_set_i];
        node_mask     = '0;
        way_sh        = '0;
        for (int lvl = 0; lvl < ways_log2_p; lvl++) begin
            way_sh    = bus.touch_way_i >> (ways_log2_p - 1 - lvl);
            node_mask = tree_t'(1) << path_node(int'(bus.touch_way_i), lvl, ways_log2_p);
            if (way_sh[0]) begin
                touched_flags = touched_flags & ~node_mask;
            end else begin
                touched_flags = touched_flags | node_mask;
            end
        end
    end

    assign lookup_flags = (touch_go && (bus.touch_set_i == bus.lookup_set_i))
                          ? touched_flags : flags_q[bus.lookup_set_i];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_free
        assign free_mask[gi] = ~bus.way_valid_i[gi] & ~bus.lock_i[gi];
    end

    always_comb begin
        free_hit = |free_mask;
        free_way = '0;
        free_sh  = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            free_sh = free_mask >> k;
            if (free_sh[0]) begin
                free_way = way_t'(k);
            end
        end
    end

    plru_tree_pick #(
        .ways_log2_p (ways_log2_p)
    ) u_pick (
        .flags_i (lookup_flags),
        .lock_i  (bus.lock_i),
        .way_o   (pick_way),
        .none_o  (pick_none)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_INIT: begin
                flags_d[sweep_q] = '0;
                sweep_d          = sweep_q + 1'b1;
                if (sweep_q == set_t'(SETS - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.touch_v_i) begin
                    flags_d[bus.touch_set_i] = touched_flags;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        victim_v_d    = lookup_go;
        victim_way_d  = victim_way_q;
        victim_none_d = victim_none_q;
        if (lookup_go) begin
            if (free_hit) begin
                victim_way_d  = free_way;
                victim_none_d = 1'b0;
            end else begin
                victim_way_d  = pick_way;
                victim_none_d = pick_none;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q       <= ST_INIT;
            sweep_q       <= '0;
            victim_v_q    <= 1'b0;
            victim_way_q  <= '0;
            victim_none_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            victim_v_q    <= victim_v_d;
            victim_way_q  <= victim_way_d;
            victim_none_q <= victim_none_d;
        end
    end

    // No reset on the flags: the init sweep clears them before any use
    always_ff @(posedge clk_i) begin
        flags_q <= flags_d;
    end

    assign bus.ready_o       = ready;
    assign bus.victim_v_o    = victim_v_q;
    assign bus.victim_way_o  = victim_way_q;
    assign bus.victim_none_o = victim_none_q;

endmodule

// File: tb/tb_plru_set_array.sv
// Directed, table-driven check of plru_set_array with 4 ways and 4 sets,
// plus hand-written init-sweep and reset sequences.
module tb_plru_set_array;

    logic clk = 1'b0;
    logic nreset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    plru_set_array_if #(.ways_log2_p(2), .sets_log2_p(2)) bus ();

    plru_set_array #(
        .ways_log2_p (2),
        .sets_log2_p (2)
    ) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    typedef struct {
        string      name;
        logic       tv;
        logic [1:0] ts;
        logic [1:0] tw;
        logic       lv;
        logic [1:0] ls;
        logic [3:0] valid;
        logic [3:0] lock;
        logic       ev;
        logic [1:0] ew;
        logic       en;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string n, input logic tv, input logic [1:0] ts,
                                input logic [1:0] tw, input logic lv, input logic [1:0] ls,
                                input logic [3:0] valid, input logic [3:0] lock,
                                input logic ev, input logic [1:0] ew, input logic en);
        vec_t r;
        r.name = n; r.tv = tv; r.ts = ts; r.tw = tw; r.lv = lv; r.ls = ls;
        r.valid = valid; r.lock = lock; r.ev = ev; r.ew = ew; r.en = en;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.touch_v_i    = 1'b0;
        bus.touch_set_i  = '0;
        bus.touch_way_i  = '0;
        bus.lookup_v_i   = 1'b0;
        bus.lookup_set_i = '0;
        bus.way_valid_i  = 4'hF;
        bus.lock_i       = 4'h0;
    endtask

    // Called at the falling edge where reset was just released
    task automatic wait_init(input bit poke);
        for (int i = 0; i <= 4; i++) begin
            chk("init_ready", bus.ready_o, (i == 4) ? 1 : 0);
            chk("init_victim_v", bus.victim_v_o, 0);
            if (poke && i == 1) begin
                bus.touch_v_i    = 1'b1;
                bus.touch_set_i  = 2'd0;
                bus.touch_way_i  = 2'd0;
                bus.lookup_v_i   = 1'b1;
                bus.lookup_set_i = 2'd0;
            end
            if (i == 2) idle_inputs();
            if (i < 4) @(negedge clk);
        end
        $display("init sweep done: ready=%0d", bus.ready_o);
    endtask

    initial begin
        //        name           tv ts tw  lv ls valid lock   ev ew en
        vq.push_back(mk("t1_set0",      0, 0, 0, 1, 0, 4'hF, 4'h0, 1, 0, 0));
        vq.push_back(mk("touch_w0",     1, 1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0));
        vq.push_back(mk("touch_w1",     1, 1, 1, 0, 0, 4'hF, 4'h0, 0, 0, 0));
        vq.push_back(mk("touch_w2",     1, 1, 2, 0, 0, 4'hF, 4'h0, 0, 0, 0));
        vq.push_back(mk("touch_w3",     1, 1, 3, 0, 0, 4'hF, 4'h0, 0, 0, 0));
        vq.push_back(mk("t2_lru0",      0, 0, 0, 1, 1, 4'hF, 4'h0, 1, 0, 0));
        vq.push_back(mk("touch_w0b",    1, 1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0));
        vq.push_back(mk("t2_lru2",      0, 0, 0, 1, 1, 4'hF, 4'h0, 1, 2, 0));
        vq.push_back(mk("t3_inv2",      0, 0, 0, 1, 1, 4'hB, 4'h0, 1, 2, 0));
        vq.push_back(mk("inv1",         0, 0, 0, 1, 1, 4'hD, 4'h0, 1, 1, 0));
        vq.push_back(mk("inv_locked",   0, 0, 0, 1, 1, 4'hB, 4'h4, 1, 3, 0));
        vq.push_back(mk("inv_lowest",   0, 0, 0, 1, 1, 4'h5, 4'h0, 1, 1, 0));
        vq.push_back(mk("retouch_w1",   1, 1, 1, 0, 0, 4'hF, 4'h0, 0, 1, 0));
        vq.push_back(mk("retouch_w2",   1, 1, 2, 0, 0, 4'hF, 4'h0, 0, 1, 0));
        vq.push_back(mk("retouch_w3",   1, 1, 3, 0, 0, 4'hF, 4'h0, 0, 1, 0));
        vq.push_back(mk("t4_tree0",     0, 0, 0, 1, 1, 4'hF, 4'h0, 1, 0, 0));
        vq.push_back(mk("t4_lock1",     0, 0, 0, 1, 1, 4'hF, 4'h1, 1, 1, 0));
        vq.push_back(mk("lock_left",    0, 0, 0, 1, 1, 4'hF, 4'h3, 1, 2, 0));
        vq.push_back(mk("lock_l_and_2", 0, 0, 0, 1, 1, 4'hF, 4'h7, 1, 3, 0));
        vq.push_back(mk("t4_all_lock",  0, 0, 0, 1, 1, 4'hF, 4'hF, 1, 0, 1));
        vq.push_back(mk("all_lock_inv", 0, 0, 0, 1, 1, 4'h0, 4'hF, 1, 0, 1));
        vq.push_back(mk("touch_w0c",    1, 1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 1));
        vq.push_back(mk("t5_bypass",    1, 1, 2, 1, 1, 4'hF, 4'h0, 1, 1, 0));
        vq.push_back(mk("t5_after",     0, 0, 0, 1, 1, 4'hF, 4'h0, 1, 1, 0));
        vq.push_back(mk("t6_other_set", 1, 2, 0, 1, 3, 4'hF, 4'h0, 1, 0, 0));
        vq.push_back(mk("t6_set2",      0, 0, 0, 1, 2, 4'hF, 4'h0, 1, 2, 0));
        vq.push_back(mk("diff_set_tl",  1, 3, 1, 1, 2, 4'hF, 4'h0, 1, 2, 0));
        vq.push_back(mk("t6_set3",      0, 0, 0, 1, 3, 4'hF, 4'h0, 1, 2, 0));

        idle_inputs();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready_o, 0);
        chk("rst_victim_v", bus.victim_v_o, 0);
        chk("rst_victim_way", bus.victim_way_o, 0);
        chk("rst_victim_none", bus.victim_none_o, 0);
        $display("reset: ready=%0d victim_v=%0d", bus.ready_o, bus.victim_v_o);

        nreset = 1'b1;
        wait_init(1'b1);

        foreach (vq[i]) begin
            bus.touch_v_i    = vq[i].tv;
            bus.touch_set_i  = vq[i].ts;
            bus.touch_way_i  = vq[i].tw;
            bus.lookup_v_i   = vq[i].lv;
            bus.lookup_set_i = vq[i].ls;
            bus.way_valid_i  = vq[i].valid;
            bus.lock_i       = vq[i].lock;
            @(negedge clk);
            chk({vq[i].name, "_v"}, bus.victim_v_o, vq[i].ev);
            chk({vq[i].name, "_way"}, bus.victim_way_o, vq[i].ew);
            chk({vq[i].name, "_none"}, bus.victim_none_o, vq[i].en);
            $display("vec %0d %s: v=%0d way=%0d none=%0d", i, vq[i].name,
                     bus.victim_v_o, bus.victim_way_o, bus.victim_none_o);
        end
        idle_inputs();

        // Reset during a lookup
        bus.lookup_v_i   = 1'b1;
        bus.lookup_set_i = 2'd1;
        nreset           = 1'b0;
        @(negedge clk);
        chk("rst_lookup_v", bus.victim_v_o, 0);
        chk("rst_lookup_ready", bus.ready_o, 0);
        $display("reset mid-lookup: victim_v=%0d", bus.victim_v_o);
        idle_inputs();
        nreset = 1'b1;

        // Reset again part-way through the sweep
        repeat (2) @(negedge clk);
        chk("mid_sweep_ready", bus.ready_o, 0);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        $display("reset mid-sweep");
        wait_init(1'b0);

        // Sweep must have cleared the trees
        bus.lookup_v_i   = 1'b1;
        bus.lookup_set_i = 2'd1;
        @(negedge clk);
        chk("cleared_set1_v", bus.victim_v_o, 1);
        chk("cleared_set1_way", bus.victim_way_o, 0);
        bus.lookup_set_i = 2'd3;
        @(negedge clk);
        chk("cleared_set3_way", bus.victim_way_o, 0);
        idle_inputs();
        @(negedge clk);
        chk("idle_v", bus.victim_v_o, 0);
        $display("post-reinit lookups: way=%0d", bus.victim_way_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
